// File: rtl/start_token_fifo_ctrl_pkg.sv
// Shared defaults and sizing helper for the start-token FIFO controller and its store.
package start_token_fifo_ctrl_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 1;
    localparam int unsigned DEF_ADDR_WIDTH = 1;
    localparam int unsigned DEF_DEPTH      = 2;

    // Minimum address bits needed to index 'depth' store entries (at least 1).
    function automatic int unsigned addr_bits(input int unsigned depth);
        int unsigned n;
        n = 1;
        for (int i = 1; i < 32; i++) begin
            if ((32'd1 << i) < depth) begin
                n = 32'(i + 1);
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/start_token_fifo_srl.sv
// Shift-register store: newest word enters at index 0, any entry readable by address.
module start_token_fifo_srl
    import start_token_fifo_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic [DATA_WIDTH-1:0] dout_c_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Shift every entry one place deeper on a write; storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[0] <= din_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    // Combinational read of the addressed entry; out-of-range addresses read zero.
    always_comb begin
        dout_c_o = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (addr_i == ADDR_WIDTH'(i)) begin
                dout_c_o = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/start_token_fifo_ctrl.sv
// Start/stream FIFO controller: write admission, store occupancy and a registered
// first-word-fall-through output stage fed from the oldest store entry.
module start_token_fifo_ctrl
    import start_token_fifo_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    logic [CNT_W-1:0]      count_q, count_d;
    logic                  out_vld_q, out_vld_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  full_n_q, full_n_d;

    logic                  push, pop, load;
    logic [ADDR_WIDTH-1:0] srl_addr;
    logic [DATA_WIDTH-1:0] srl_dout;

    // Handshake qualifiers; full_n_q always equals (count_q != DEPTH).
    assign push     = if_write & if_write_ce & full_n_q;
    assign pop      = if_read & if_read_ce & out_vld_q;
    assign load     = if_read_ce & (count_q != '0) & (~out_vld_q | pop);
    assign srl_addr = (count_q == '0) ? '0 : ADDR_WIDTH'(count_q - CNT_W'(1));

    start_token_fifo_srl #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_srl (
        .clk      (clk),
        .we_i     (push),
        .addr_i   (srl_addr),
        .din_i    (if_din),
        .dout_c_o (srl_dout)
    );

    // Next occupancy, output stage and full flag; load wins over pop for the output stage.
    always_comb begin
        count_d    = count_q + CNT_W'(push) - CNT_W'(load);
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        if (load) begin
            out_vld_d  = 1'b1;
            out_data_d = srl_dout;
        end else if (pop) begin
            out_vld_d  = 1'b0;
        end
        full_n_d   = (count_d != CNT_W'(DEPTH));
    end

    // State registers with synchronous reset discarding all contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            full_n_q   <= 1'b1;
        end else begin
            count_q    <= count_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            full_n_q   <= full_n_d;
        end
    end

    assign if_full_n  = full_n_q;
    assign if_empty_n = out_vld_q;
    assign if_dout    = out_data_q;

    // Occupancy must stay within the store, and the address port must reach every entry.
    count_in_range: assert property (@(posedge clk) disable iff (reset)
        count_q <= CNT_W'(DEPTH));
    addr_fits_depth: assert property (@(posedge clk)
        ADDR_WIDTH >= addr_bits(DEPTH));

endmodule

// File: tb/tb_start_token_fifo_ctrl.sv
// Self-checking bench: hand-computed vector table, then scoreboard-driven sequences
// (streaming, full+read, reset mid-operation, random traffic) against a queue model.
module tb_start_token_fifo_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 1;
    localparam int unsigned DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_write_ce, if_write, if_full_n;
    logic          if_read_ce, if_read, if_empty_n;
    logic [DW-1:0] if_din, if_dout;

    always #5 clk = ~clk;

    start_token_fifo_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .if_write_ce (if_write_ce),
        .if_write    (if_write),
        .if_din      (if_din),
        .if_full_n   (if_full_n),
        .if_read_ce  (if_read_ce),
        .if_read     (if_read),
        .if_dout     (if_dout),
        .if_empty_n  (if_empty_n)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- table-driven vectors ----------------
    typedef struct {
        logic          rst, wce, w, rce, r;
        logic [DW-1:0] din;
        logic          exp_full_n, exp_empty_n, chk_dout;
        logic [DW-1:0] exp_dout;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic rst, input logic wce, input logic w,
                                input logic rce, input logic r, input logic [DW-1:0] din,
                                input logic efn, input logic een, input logic chk,
                                input logic [DW-1:0] edo);
        vec_t v;
        v.rst = rst; v.wce = wce; v.w = w; v.rce = rce; v.r = r; v.din = din;
        v.exp_full_n = efn; v.exp_empty_n = een; v.chk_dout = chk; v.exp_dout = edo;
        return v;
    endfunction

    // ---------------- scoreboard model ----------------
    int            m_cnt = 0;
    logic          m_vld = 1'b0;
    logic [DW-1:0] sb[$];
    int            dut_reads = 0;

    task automatic cycle(input logic rst, input logic wce, input logic w, input logic [DW-1:0] din,
                         input logic rce, input logic r);
        logic          push, pop, load;
        logic [DW-1:0] e;
        reset = rst; if_write_ce = wce; if_write = w; if_din = din;
        if_read_ce = rce; if_read = r;
        push = w & wce & (m_cnt != int'(DEPTH));
        pop  = r & rce & m_vld;
        load = rce & (m_cnt != 0) & (~m_vld | pop);
        if (!rst && if_empty_n && r && rce) dut_reads++;
        if (!rst && pop) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check("sb_pop_data", 32'(if_dout), 32'(e));
            end
        end
        @(posedge clk); #1;
        if (rst) begin
            m_cnt = 0; m_vld = 1'b0; sb.delete();
        end else begin
            if (push) sb.push_back(din);
            m_cnt = m_cnt + int'(push) - int'(load);
            if (load) m_vld = 1'b1;
            else if (pop) m_vld = 1'b0;
        end
        check("full_n", 32'(if_full_n), 32'(m_cnt != int'(DEPTH)));
        check("empty_n", 32'(if_empty_n), 32'(m_vld));
        if (m_vld && sb.size() != 0) check("dout_head", 32'(if_dout), 32'(sb[0]));
    endtask

    initial begin
        reset = 1'b1; if_write_ce = 1'b0; if_write = 1'b0; if_din = '0;
        if_read_ce = 1'b0; if_read = 1'b0;

        //                rst   wce   w     rce   r     din    full_n empty_n chk  dout
        vecs[0]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00); // reset
        vecs[1]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h0A, 1'b1, 1'b0, 1'b0, 8'h00); // write A
        vecs[2]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h0A); // A visible
        vecs[3]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00); // read A
        vecs[4]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 8'h00); // write 1
        vecs[5]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h02, 1'b1, 1'b1, 1'b1, 8'h01); // write 2, 1 loads
        vecs[6]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h03, 1'b0, 1'b1, 1'b1, 8'h01); // write 3 -> full
        vecs[7]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h04, 1'b0, 1'b1, 1'b1, 8'h01); // write 4 ignored
        vecs[8]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 8'h02); // read -> 2
        vecs[9]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 8'h03); // read -> 3
        vecs[10] = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00); // read 3 -> empty
        vecs[11] = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00); // read when empty
        vecs[12] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h07, 1'b1, 1'b0, 1'b0, 8'h00); // write 7
        vecs[13] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00); // read_ce=0 holds load
        vecs[14] = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h07); // 7 loads
        vecs[15] = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h09, 1'b1, 1'b1, 1'b1, 8'h07); // write_ce=0 blocks
        vecs[16] = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00); // read 7, 9 absent

        for (int i = 0; i < NV; i++) begin
            reset = vecs[i].rst; if_write_ce = vecs[i].wce; if_write = vecs[i].w;
            if_din = vecs[i].din; if_read_ce = vecs[i].rce; if_read = vecs[i].r;
            @(posedge clk); #1;
            check($sformatf("vec%0d_full_n", i), 32'(if_full_n), 32'(vecs[i].exp_full_n));
            check($sformatf("vec%0d_empty_n", i), 32'(if_empty_n), 32'(vecs[i].exp_empty_n));
            if (vecs[i].chk_dout) begin
                check($sformatf("vec%0d_dout", i), 32'(if_dout), 32'(vecs[i].exp_dout));
            end
        end

        // Reset model and DUT together before scoreboard phase.
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("post_reset_dout", 32'(if_dout), 32'd0);

        // Streaming: write and read every cycle, 16 words, then drain.
        dut_reads = 0;
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 1'b1, DW'(i), 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        check("stream_reads", 32'(dut_reads), 32'd16);
        check("stream_empty", 32'(if_empty_n), 32'd0);

        // Full plus simultaneous read: write refused that cycle, accepted next.
        cycle(1'b0, 1'b1, 1'b1, 8'h21, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 8'h23, 1'b1, 1'b0);
        check("full_reached", 32'(if_full_n), 32'd0);
        cycle(1'b0, 1'b1, 1'b1, 8'h24, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 8'h24, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        check("full_drained", 32'(sb.size()), 32'd0);

        // Reset with two words stored, then a fresh write.
        cycle(1'b0, 1'b1, 1'b1, 8'h31, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 8'h32, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("rst_mid_full_n", 32'(if_full_n), 32'd1);
        check("rst_mid_empty_n", 32'(if_empty_n), 32'd0);
        cycle(1'b0, 1'b1, 1'b1, 8'h05, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        check("rst_new_word", 32'(if_dout), 32'h05);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);

        // Random traffic including enables and occasional resets.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), DW'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        check("final_empty", 32'(if_empty_n), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
